// File: rtl/fsm_self_test_mc.sv
// fsm_self_test_mc
//   Multi-channel frame-grabber self-test. For each fg_signal channel it
//   synchronises the input, counts rising edges, measures the edge-to-edge
//   period and the high width, and emits a one-cycle trigger fg_delay clocks
//   after each rising edge. It flags sticky timeout and retrigger (overlap)
//   faults.
// Ports
//   clock, reset       rising-edge clock, synchronous active-high reset
//   enable             1 = measure, 0 = every channel idle and cleared
//   fg_signal          asynchronous fg opto inputs, one bit per channel
//   fg_delay           trigger delay in clocks, shared by all channels
//   counter_out        rising-edge count, channel i at [i*CNT_W +: CNT_W]
//   period_out         last edge-to-edge period, clocks
//   width_out          last high width, clocks
//   period_valid       one-cycle strobe, period_out updated
//   width_valid        one-cycle strobe, width_out updated
//   trig_out           one-cycle delayed trigger pulse
//   err_timeout        sticky, no rising edge for TIMEOUT clocks
//   err_overlap        sticky, rising edge while a trigger was still pending
module fsm_self_test_mc #(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 8_000_000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [CHANNELS-1:0]       fg_signal,
  input  logic [CNT_W-1:0]          fg_delay,
  output logic [CHANNELS*CNT_W-1:0] counter_out,
  output logic [CHANNELS*CNT_W-1:0] period_out,
  output logic [CHANNELS*CNT_W-1:0] width_out,
  output logic [CHANNELS-1:0]       period_valid,
  output logic [CHANNELS-1:0]       width_valid,
  output logic [CHANNELS-1:0]       trig_out,
  output logic [CHANNELS-1:0]       err_timeout,
  output logic [CHANNELS-1:0]       err_overlap
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_HIGH, S_LOW} state_t;

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   synced, rise, fall, tmo;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, since_q, wcnt_q, per_q, wid_q, dcnt_q;
    logic                   pend_q, trig_q, pv_q, wv_q, et_q, eo_q;

    // The synchroniser runs regardless of enable so a level already high
    // at re-enable is not mistaken for a new edge.
    always_ff @(posedge clock) begin
      if (reset) begin
        sync_q <= '0;
        prev_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], fg_signal[g]};
        prev_q <= synced;
      end
    end

    assign synced = sync_q[SYNC_STAGES-1];
    assign rise   = synced & ~prev_q;
    assign fall   = ~synced & prev_q;
    // since_q is j in cycle E+j, so matching TIMEOUT-1 makes the flag
    // visible exactly TIMEOUT clocks after the edge. An edge in that same
    // cycle wins over the timeout.
    assign tmo    = (state_q != S_IDLE) && (since_q == TO_LAST) && !rise;

    always_comb begin
      state_d = state_q;
      unique case (state_q)
        S_IDLE: state_d = S_ARM;
        S_ARM:  if (rise) state_d = S_HIGH;
        S_HIGH: if (tmo) state_d = S_ARM; else if (fall) state_d = S_LOW;
        S_LOW:  if (tmo) state_d = S_ARM; else if (rise) state_d = S_HIGH;
        default: state_d = S_IDLE;
      endcase
      if (!enable) state_d = S_IDLE;
    end

    always_ff @(posedge clock) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
    end

    always_ff @(posedge clock) begin
      if (reset || !enable) begin
        cnt_q   <= '0;
        since_q <= '0;
        wcnt_q  <= '0;
        per_q   <= '0;
        wid_q   <= '0;
        dcnt_q  <= '0;
        pend_q  <= 1'b0;
        trig_q  <= 1'b0;
        pv_q    <= 1'b0;
        wv_q    <= 1'b0;
        et_q    <= 1'b0;
        eo_q    <= 1'b0;
      end else begin
        pv_q   <= 1'b0;
        wv_q   <= 1'b0;
        trig_q <= 1'b0;

        if (rise)                           since_q <= ONE;
        else if (state_q == S_IDLE || tmo)  since_q <= '0;
        else if (since_q != '1)             since_q <= since_q + ONE;

        if (rise)                wcnt_q <= ONE;
        else if (wcnt_q != '1)   wcnt_q <= wcnt_q + ONE;

        if (rise && (state_q == S_ARM || state_q == S_LOW))
          cnt_q <= cnt_q + ONE;

        if (rise && state_q == S_LOW) begin
          per_q <= since_q;
          pv_q  <= 1'b1;
        end

        if (fall && state_q == S_HIGH && !tmo) begin
          wid_q <= wcnt_q;
          wv_q  <= 1'b1;
        end

        if (tmo) et_q <= 1'b1;

        // dcnt_q holds the clocks still to wait; the pulse is registered
        // when it reaches 1 so it appears in cycle E+fg_delay+1. A zero
        // delay fires straight from the edge.
        if (rise) begin
          if (pend_q) eo_q <= 1'b1;
          if (fg_delay == '0) begin
            trig_q <= 1'b1;
            pend_q <= 1'b0;
          end else begin
            pend_q <= 1'b1;
            dcnt_q <= fg_delay;
          end
        end else if (pend_q) begin
          if (dcnt_q == ONE) begin
            trig_q <= 1'b1;
            pend_q <= 1'b0;
          end
          dcnt_q <= dcnt_q - ONE;
        end
      end
    end

    assign counter_out[g*CNT_W +: CNT_W] = cnt_q;
    assign period_out[g*CNT_W +: CNT_W]  = per_q;
    assign width_out[g*CNT_W +: CNT_W]   = wid_q;
    assign period_valid[g]               = pv_q;
    assign width_valid[g]                = wv_q;
    assign trig_out[g]                   = trig_q;
    assign err_timeout[g]                = et_q;
    assign err_overlap[g]                = eo_q;
  end

endmodule

// File: tb/tb_fsm_self_test_mc.sv
// tb_fsm_self_test_mc
//   Directed bench for fsm_self_test_mc: a 4-channel 32-bit instance with a
//   short TIMEOUT, plus a 1-channel 8-bit instance for counter wrap.
//   Cycle X is the interval after the X-th rising clock edge. An input
//   driven in cycle k gives the edge event E in cycle k+2.
module tb_fsm_self_test_mc;
  localparam int CH  = 4;
  localparam int W   = 32;
  localparam int TO  = 6000;
  localparam int W2  = 8;
  localparam int TO2 = 200;

  logic clk = 1'b0;
  logic reset, enable, enable2;
  logic fg_ch [CH];
  logic [CH-1:0] fg_vec;
  logic [0:0] fg2;
  logic [W-1:0] fg_delay;
  logic [W2-1:0] fg_delay2;

  logic [CH*W-1:0] counter_out, period_out, width_out;
  logic [CH-1:0] period_valid, width_valid, trig_out, err_timeout, err_overlap;
  logic [W2-1:0] counter_out2, period_out2, width_out2;
  logic [0:0] period_valid2, width_valid2, trig_out2, err_timeout2, err_overlap2;

  logic [3*CH*W+5*CH-1:0] all_out;
  logic [3*W2+4:0] all_out2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int pv_tot [CH] = '{default: 0};
  int trig_tot [CH] = '{default: 0};
  int trig_log [CH][64];
  int ov_rise [CH] = '{default: -1};
  int to_rise [CH] = '{default: -1};
  logic [CH-1:0] ov_prev = '0, to_prev = '0;
  int rise_cyc [CH][8];
  int rise2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < CH; i++) fg_vec[i] = fg_ch[i];
  end

  assign all_out  = {counter_out, period_out, width_out, period_valid, width_valid,
                     trig_out, err_timeout, err_overlap};
  assign all_out2 = {counter_out2, period_out2, width_out2, period_valid2, width_valid2,
                     trig_out2, err_timeout2, err_overlap2};

  fsm_self_test_mc #(.CHANNELS(CH), .CNT_W(W), .SYNC_STAGES(2), .TIMEOUT(TO)) dut (
    .clock(clk), .reset(reset), .enable(enable), .fg_signal(fg_vec), .fg_delay(fg_delay),
    .counter_out(counter_out), .period_out(period_out), .width_out(width_out),
    .period_valid(period_valid), .width_valid(width_valid), .trig_out(trig_out),
    .err_timeout(err_timeout), .err_overlap(err_overlap));

  fsm_self_test_mc #(.CHANNELS(1), .CNT_W(W2), .SYNC_STAGES(2), .TIMEOUT(TO2)) dut8 (
    .clock(clk), .reset(reset), .enable(enable2), .fg_signal(fg2), .fg_delay(fg_delay2),
    .counter_out(counter_out2), .period_out(period_out2), .width_out(width_out2),
    .period_valid(period_valid2), .width_valid(width_valid2), .trig_out(trig_out2),
    .err_timeout(err_timeout2), .err_overlap(err_overlap2));

  // Event recorder for the 4-channel instance, sampled mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < CH; i++) begin
      if (period_valid[i]) pv_tot[i]++;
      if (trig_out[i]) begin
        if (trig_tot[i] < 64) trig_log[i][trig_tot[i]] = cyc;
        trig_tot[i]++;
      end
      if (err_overlap[i] && !ov_prev[i]) ov_rise[i] = cyc;
      if (err_timeout[i] && !to_prev[i]) to_rise[i] = cyc;
    end
    ov_prev = err_overlap;
    to_prev = err_timeout;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_ch(input int ch, input int n, input int high, input int period);
    for (int p = 0; p < n; p++) begin
      rise_cyc[ch][p] = cyc;
      fg_ch[ch] = 1'b1;
      step(high);
      fg_ch[ch] = 1'b0;
      step(period - high);
    end
  endtask

  task automatic drive8(input int n, input int high, input int period);
    for (int p = 0; p < n; p++) begin
      rise2 = cyc;
      fg2 = 1'b1;
      step(high);
      fg2 = 1'b0;
      step(period - high);
    end
  endtask

  task automatic restart();
    enable = 1'b0;
    step(2);
    enable = 1'b1;
    step(2);
  endtask

  task automatic test_reset();
    int pv0, tr0, k;
    reset = 1'b1; enable = 1'b0; enable2 = 1'b0;
    step(3);
    checks++;
    if (all_out !== '0 || all_out2 !== '0) begin
      failures++; $display("FAIL reset_state got=%h exp=0", all_out);
    end
    reset = 1'b0; enable = 1'b1; enable2 = 1'b1;
    step(2);
    fg_delay = 100;
    drive_ch(0, 2, 10, 50);
    checks++;
    if (counter_out[W-1:0] !== 32'd2) begin
      failures++; $display("FAIL reset_precount got=%0d exp=2", counter_out[W-1:0]);
    end
    reset = 1'b1;
    step(1);
    checks++;
    if (all_out !== '0) begin
      failures++; $display("FAIL reset_mid got=%h exp=0", all_out);
    end
    reset = 1'b0;
    pv0 = pv_tot[0]; tr0 = trig_tot[0];
    step(1);
    k = cyc;
    drive_ch(0, 1, 10, 50);
    step(100);
    checks++;
    if (counter_out[W-1:0] !== 32'd1) begin
      failures++; $display("FAIL reset_first_count got=%0d exp=1", counter_out[W-1:0]);
    end
    checks++;
    if (pv_tot[0] - pv0 !== 0) begin
      failures++; $display("FAIL reset_no_pv got=%0d exp=0", pv_tot[0] - pv0);
    end
    checks++;
    if (trig_tot[0] - tr0 !== 1) begin
      failures++; $display("FAIL reset_trig_count got=%0d exp=1", trig_tot[0] - tr0);
    end else begin
      checks++;
      if (trig_log[0][tr0] !== k + 103) begin
        failures++; $display("FAIL reset_trig_time got=%0d exp=%0d", trig_log[0][tr0], k + 103);
      end
    end
  endtask

  task automatic test_nominal();
    int pv0, tr0;
    restart();
    fg_delay = 1800;
    pv0 = pv_tot[0]; tr0 = trig_tot[0];
    drive_ch(0, 5, 40, 4000);
    checks++;
    if (counter_out[W-1:0] !== 32'd5) begin
      failures++; $display("FAIL nom_count got=%0d exp=5", counter_out[W-1:0]);
    end
    checks++;
    if (period_out[W-1:0] !== 32'd4000) begin
      failures++; $display("FAIL nom_period got=%0d exp=4000", period_out[W-1:0]);
    end
    checks++;
    if (pv_tot[0] - pv0 !== 4) begin
      failures++; $display("FAIL nom_pv_strobes got=%0d exp=4", pv_tot[0] - pv0);
    end
    checks++;
    if (width_out[W-1:0] !== 32'd40) begin
      failures++; $display("FAIL nom_width got=%0d exp=40", width_out[W-1:0]);
    end
    checks++;
    if (trig_tot[0] - tr0 !== 5) begin
      failures++; $display("FAIL nom_trig_count got=%0d exp=5", trig_tot[0] - tr0);
    end else begin
      for (int p = 0; p < 5; p++) begin
        checks++;
        if (trig_log[0][tr0 + p] !== rise_cyc[0][p] + 1803) begin
          failures++;
          $display("FAIL nom_trig_time p=%0d got=%0d exp=%0d", p, trig_log[0][tr0 + p],
                   rise_cyc[0][p] + 1803);
        end
      end
    end
    checks++;
    if (counter_out[CH*W-1:W] !== '0 || period_out[CH*W-1:W] !== '0 ||
        width_out[CH*W-1:W] !== '0 || trig_out[CH-1:1] !== '0) begin
      failures++; $display("FAIL nom_other_ch got=%h exp=0", counter_out[CH*W-1:W]);
    end
    checks++;
    if (err_overlap[0] !== 1'b0) begin
      failures++; $display("FAIL nom_no_overlap got=%b exp=0", err_overlap[0]);
    end
  endtask

  task automatic test_overlap();
    int tr0;
    restart();
    fg_delay = 5000;
    tr0 = trig_tot[0];
    drive_ch(0, 1, 40, 4000);
    checks++;
    if (err_overlap[0] !== 1'b0) begin
      failures++; $display("FAIL ovl_before got=%b exp=0", err_overlap[0]);
    end
    drive_ch(0, 2, 40, 4000);
    // drive_ch restarts its record at index 0; rise_cyc[0][0] is the 2nd edge
    checks++;
    if (ov_rise[0] !== rise_cyc[0][0] + 3) begin
      failures++; $display("FAIL ovl_set_time got=%0d exp=%0d", ov_rise[0], rise_cyc[0][0] + 3);
    end
    step(1100);
    checks++;
    if (err_overlap[0] !== 1'b1) begin
      failures++; $display("FAIL ovl_sticky got=%b exp=1", err_overlap[0]);
    end
    checks++;
    if (trig_tot[0] - tr0 !== 1) begin
      failures++; $display("FAIL ovl_trig_count got=%0d exp=1", trig_tot[0] - tr0);
    end else begin
      checks++;
      if (trig_log[0][tr0] !== rise_cyc[0][1] + 5003) begin
        failures++;
        $display("FAIL ovl_trig_time got=%0d exp=%0d", trig_log[0][tr0], rise_cyc[0][1] + 5003);
      end
    end
  endtask

  task automatic test_timeout();
    int pv0, last_k;
    restart();
    fg_delay = 10;
    drive_ch(1, 2, 20, 1000);
    last_k = rise_cyc[1][1];
    step(5100);
    checks++;
    if (to_rise[1] !== last_k + 2 + TO) begin
      failures++; $display("FAIL tmo_set_time got=%0d exp=%0d", to_rise[1], last_k + 2 + TO);
    end
    pv0 = pv_tot[1];
    drive_ch(1, 1, 20, 1000);
    checks++;
    if (pv_tot[1] - pv0 !== 0) begin
      failures++; $display("FAIL tmo_resume_no_pv got=%0d exp=0", pv_tot[1] - pv0);
    end
    drive_ch(1, 1, 20, 1000);
    checks++;
    if (pv_tot[1] - pv0 !== 1 || period_out[W +: W] !== 32'd1000) begin
      failures++;
      $display("FAIL tmo_resume_period got=%0d/%0d exp=1/1000", pv_tot[1] - pv0, period_out[W +: W]);
    end
    checks++;
    if (counter_out[W +: W] !== 32'd4 || err_timeout[1] !== 1'b1) begin
      failures++;
      $display("FAIL tmo_count_sticky got=%0d/%b exp=4/1", counter_out[W +: W], err_timeout[1]);
    end
  endtask

  task automatic test_parallel();
    int tr0 [CH];
    int hi [CH] = '{5, 7, 9, 11};
    int per [CH] = '{100, 130, 170, 210};
    restart();
    fg_delay = 0;
    for (int i = 0; i < CH; i++) tr0[i] = trig_tot[i];
    fork
      drive_ch(0, 3, 5, 100);
      drive_ch(1, 3, 7, 130);
      drive_ch(2, 3, 9, 170);
      drive_ch(3, 3, 11, 210);
    join
    for (int i = 0; i < CH; i++) begin
      checks++;
      if (counter_out[i*W +: W] !== 32'd3) begin
        failures++; $display("FAIL par_count ch=%0d got=%0d exp=3", i, counter_out[i*W +: W]);
      end
      checks++;
      if (period_out[i*W +: W] !== per[i]) begin
        failures++;
        $display("FAIL par_period ch=%0d got=%0d exp=%0d", i, period_out[i*W +: W], per[i]);
      end
      checks++;
      if (width_out[i*W +: W] !== hi[i]) begin
        failures++;
        $display("FAIL par_width ch=%0d got=%0d exp=%0d", i, width_out[i*W +: W], hi[i]);
      end
      checks++;
      if (trig_log[i][tr0[i]] !== rise_cyc[i][0] + 3 || trig_tot[i] - tr0[i] !== 3) begin
        failures++;
        $display("FAIL par_trig_d0 ch=%0d got=%0d exp=%0d", i, trig_log[i][tr0[i]], rise_cyc[i][0] + 3);
      end
    end
  endtask

  task automatic test_wrap8();
    fg_delay2 = '0;
    drive8(255, 2, 6);
    checks++;
    if (counter_out2 !== 8'd255) begin
      failures++; $display("FAIL wrap_255 got=%0d exp=255", counter_out2);
    end
    drive8(1, 2, 6);
    checks++;
    if (counter_out2 !== 8'd0) begin
      failures++; $display("FAIL wrap_0 got=%0d exp=0", counter_out2);
    end
    drive8(1, 2, 6);
    checks++;
    if (counter_out2 !== 8'd1 || period_out2 !== 8'd6 || width_out2 !== 8'd2) begin
      failures++;
      $display("FAIL wrap_1 got=%0d/%0d/%0d exp=1/6/2", counter_out2, period_out2, width_out2);
    end
  endtask

  task automatic test_enable_drop();
    int tr0, pv0;
    restart();
    fg_delay = 500;
    drive_ch(0, 1, 40, 100);
    fg_ch[2] = 1'b1;
    step(5);
    enable = 1'b0;
    step(1);
    checks++;
    if (all_out !== '0) begin
      failures++; $display("FAIL en_drop_zero got=%h exp=0", all_out);
    end
    tr0 = trig_tot[0];
    step(600);
    checks++;
    if (trig_tot[0] - tr0 !== 0) begin
      failures++; $display("FAIL en_drop_no_trig got=%0d exp=0", trig_tot[0] - tr0);
    end
    fg_ch[2] = 1'b0;
    step(3);
    enable = 1'b1;
    step(3);
    tr0 = trig_tot[0]; pv0 = pv_tot[0];
    drive_ch(0, 1, 40, 600);
    checks++;
    if (counter_out[W-1:0] !== 32'd1 || pv_tot[0] - pv0 !== 0 || counter_out[2*W +: W] !== '0) begin
      failures++;
      $display("FAIL en_rearm got=%0d/%0d exp=1/0", counter_out[W-1:0], pv_tot[0] - pv0);
    end
    checks++;
    if (trig_tot[0] - tr0 !== 1 || trig_log[0][tr0] !== rise_cyc[0][0] + 503) begin
      failures++;
      $display("FAIL en_rearm_trig got=%0d exp=%0d", trig_log[0][tr0], rise_cyc[0][0] + 503);
    end
  endtask

  initial begin
    for (int i = 0; i < CH; i++) fg_ch[i] = 1'b0;
    fg2 = 1'b0;
    fg_delay = '0;
    fg_delay2 = '0;
    reset = 1'b1;
    enable = 1'b0;
    enable2 = 1'b0;
    #1;
    test_reset();
    test_nominal();
    test_overlap();
    test_timeout();
    test_parallel();
    test_wrap8();
    test_enable_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
